// File: rtl/fifo_wr_skid.sv
// fifo_wr_skid: two-entry skid buffer turning a valid/ready stream into winc/wdata; FIFO_WR_STATS_EN adds stall_cnt
module fifo_wr_skid #(
  parameter int DATASIZE = 8
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATASIZE-1:0] s_data,
  input  logic                full,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata
`ifdef FIFO_WR_STATS_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_nx;
  logic [DATASIZE-1:0] h, s;
  logic accept, pop;
  assign accept = s_valid & s_ready;
  assign pop    = winc & ~full;
  always_ff @(posedge wclk)
    if (!wrst_n) state <= EMPTY;
    else         state <= state_nx;
  always_comb
    state_nx = (state == EMPTY) ? (accept ? ONE : EMPTY) :
               (state == ONE)   ? ((accept && !pop) ? TWO : (!accept && pop) ? EMPTY : ONE) :
               (pop ? ONE : TWO);
  always_comb begin
    winc  = (state != EMPTY);
    wdata = h;
  end
  // H always holds the oldest word; S only fills while H is stuck
  always_ff @(posedge wclk)
    if (!wrst_n) begin
      h       <= '0;
      s       <= '0;
      s_ready <= 1'b0;
    end else begin
      s_ready <= (state_nx != TWO);
      if ((state == EMPTY && accept) || (state == ONE && accept && pop)) h <= s_data;
      else if (state == TWO && pop)                                      h <= s;
      if (state == ONE && accept && !pop) s <= s_data;
    end
`ifdef FIFO_WR_STATS_EN
  always_ff @(posedge wclk)
    if (!wrst_n)                                    stall_cnt <= '0;
    else if (winc && full && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_fifo_wr_skid.sv
// tb_fifo_wr_skid: queue-based scoreboard for fifo_wr_skid; stats checks need FIFO_WR_STATS_EN
module tb_fifo_wr_skid;
  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       full = 1'b0;
  logic       winc;
  logic [7:0] wdata;
`ifdef FIFO_WR_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] stall_m = '0;
`endif
  logic [7:0] exp_q[$];
  logic       rdy_m = 1'b0;
  logic       clean = 1'b0;
  logic       armed = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  fifo_wr_skid #(.DATASIZE(8)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .full(full), .winc(winc), .wdata(wdata)
`ifdef FIFO_WR_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Model: exp_q is every accepted word not yet written; ready iff fewer than two are held.
  task automatic cyc(input logic v, input logic [7:0] d, input logic f, input logic rn);
    @(negedge wclk);
    s_valid = v;
    s_data  = d;
    full    = f;
    wrst_n  = rn;
    #2;
    if (!wrst_n) begin
      exp_q.delete();
      rdy_m = 1'b0;
      clean = 1'b1;
      armed = 1'b1;
`ifdef FIFO_WR_STATS_EN
      stall_m = '0;
`endif
    end else begin
`ifdef FIFO_WR_STATS_EN
      if (full && exp_q.size() != 0 && stall_m != 16'hFFFF) stall_m++;
`endif
      if (s_valid && rdy_m) begin
        exp_q.push_back(s_data);
        clean = 1'b0;
      end
      rdy_m = (exp_q.size() < 2);
    end
  endtask

  always @(negedge wclk) begin
    #1;
    if (armed) begin
      chk("s_ready", 32'(s_ready), 32'(rdy_m));
      chk("winc", 32'(winc), 32'(exp_q.size() != 0));
      if (clean) chk("wdata_after_reset", 32'(wdata), 32'h0);
`ifdef FIFO_WR_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
`endif
      if (winc) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_write at %0t: got wdata %0h, expected no pending word", $time, wdata);
        end else begin
          chk("wdata", 32'(wdata), 32'(exp_q[0]));
          if (!full) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h20, 1'b0, 1'b1);
    cyc(1'b1, 8'h21, 1'b0, 1'b1);
    cyc(1'b1, 8'h22, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h23 + 8'(i), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h40, 1'b0, 1'b1);
    cyc(1'b1, 8'h41, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 8'h42, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
`ifdef FIFO_WR_STATS_EN
    cyc(1'b1, 8'h55, 1'b1, 1'b1);
    for (int i = 0; i < 70000; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("stall_saturated", 32'(stall_cnt), 32'hFFFF);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
`endif
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d words still pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
